seg7_scan_decode: RTL and testbench
===================================

// Module: seg7_scan_decode
// PURPOSE
//  Receive-side counterpart of the 7-segment encoder. Snoops the multiplexed display bus
//  (segment code + digit anode select) and rebuilds the hex value of each digit.
//  Used as an on-chip self-check and for readback of the displayed MNIST result.
//  A code is committed only after it has stayed stable for STABLE_CYCLES samples.
// PARAMETERS
//  NUM_DIGITS     8  number of multiplexed digits; legal range 2..16
//  STABLE_CYCLES  4  identical consecutive samples required before commit; must be >=1
// PORTS
//  clk       in   1             clock
//  rst       in   1             reset, asynchronous, active-high
//  seg_code  in   8             {dp,g,f,e,d,c,b,a}; segments active-high
//  an_n      in   NUM_DIGITS    digit select, active-low; exactly one low = valid select
//  digits    out  NUM_DIGITS*4  decoded nibbles; digit i at [4i+3:4i]
//  dvalid    out  NUM_DIGITS    bit i=1: digits[i] holds a good decoded value
//  upd       out  1             1-cycle pulse on each successful commit
//  upd_idx   out  clog2(ND)     digit index of the last commit (valid with upd)
//  code_err  out  1             1-cycle pulse: stable code not found in the table
//  sel_err   out  1             1-cycle pulse: more than one an_n bit low in a sample
//  dp        out  NUM_DIGITS    captured decimal-point bits (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs and internal state are 0. This includes digits, dvalid, upd,
//   upd_idx, code_err, sel_err, dp, the sample regs and the run counter.
//  Sampling: seg_code and an_n are registered every cycle (1 stage), giving sample S.
//   All further logic uses S only.
//  Decode table, seg_code[6:0] -> nibble:
//   3F:0  06:1  5B:2  4F:3  66:4  6D:5  7D:6  07:7
//   7F:8  6F:9  77:A  7C:b  39:C  5E:d  79:E  71:F
//   Any other code is invalid. seg_code[7] is ignored by the decode.
//  Run tracking:
//   A sample is a "select" when exactly one an_n bit is low.
//   If S is a select and S equals the previous sample (same an_n, same seg_code[6:0]),
//    the counter increments, saturating at STABLE_CYCLES.
//   If S is a select but differs from the previous sample, the counter is set to 1.
//   If all an_n bits are high (blank), the counter is set to 0 and nothing commits.
//   If 2 or more an_n bits are low, the counter is set to 0, sel_err pulses,
//    and nothing commits.
//  Commit: happens once per run, on the sample where the counter reaches STABLE_CYCLES.
//   If inputs are held from edge k, outputs change at edge k+STABLE_CYCLES.
//   No further commit occurs until the run breaks.
//   Valid code: digits[i] is written, dvalid[i]=1, upd=1, upd_idx=i.
//   Invalid code: digits[i] keeps its value, dvalid[i]=0, code_err=1, upd stays 0.
//  Scan wrap: after the last digit the scan returns to index 0. Each digit commits
//   independently; other digits are never disturbed.
//  Reset mid-run: the run is aborted. After release, a full new run of
//   STABLE_CYCLES samples is needed.
//  upd, code_err and sel_err are single-cycle pulses. upd and code_err never assert
//   in the same cycle.
// CONFIGURATION
//  SEG7_DP_CAPTURE_EN defined: on every commit (valid or invalid code),
//   dp[i] <= seg_code[7] of the committed sample.
//  SEG7_DP_CAPTURE_EN undefined: dp is tied to 0 and no dp flops are built.
//   seg_code[7] is unused.
// TESTING
//  1. Reset, then an_n=8'hFE, seg_code=8'hBF held 4 cycles
//     -> digits[3:0]=0, dvalid[0]=1, upd one pulse with upd_idx=0, at edge k+4.
//  2. Scan digits 0..7 with codes for 1..8 (86,DB,CF,E6,ED,FD,87,FF), 6 cycles each
//     -> digits=32'h87654321, dvalid=8'hFF, exactly 8 upd pulses.
//  3. an_n=8'hFB, seg_code=8'h80 held 5 cycles
//     -> one code_err pulse, dvalid[2]=0, digits[2] unchanged, no upd.
//  4. an_n=8'hFC (two digits low) for 3 cycles
//     -> sel_err pulses 3 times, no commit. Next, code F7 on digit 1 held 3 cycles
//        then changed -> no commit (run of 3 < 4).
//  5. Assert rst after 2 stable cycles of a run -> all outputs 0. After release the
//     same input needs 4 cycles to commit.
//  6. With SEG7_DP_CAPTURE_EN: commit 8'h6F on digit 3 -> digits[3]=9, dp[3]=0.
//     Commit 8'hEF -> dp[3]=1. Without the macro, dp stays 8'h00 in both cases.

Source files
------------

// File: rtl/seg7_scan_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_decode
// Description : Snoops a multiplexed 7-segment display bus (segment code plus
//               active-low anode select) and rebuilds the hex nibble shown on
//               each digit. A code commits once it has been seen unchanged for
//               STABLE_CYCLES consecutive samples.
//               Optional feature macro: SEG7_DP_CAPTURE_EN (capture the
//               decimal-point bit of each committed sample into dp).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decode #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    seg_code,
  input  logic [NUM_DIGITS-1:0]         an_n,
  output logic [NUM_DIGITS*4-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         dvalid,
  output logic                          upd,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx,
  output logic                          code_err,
  output logic                          sel_err,
  output logic [NUM_DIGITS-1:0]         dp
);

  localparam int c_idx_w = $clog2(NUM_DIGITS);
  localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);

  // Sample stage (S) and the previous sample used for run detection
  logic [NUM_DIGITS-1:0]   an_s_q, an_s_d, an_p_q, an_p_d;
  logic [6:0]              seg_s_q, seg_s_d, seg_p_q, seg_p_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;

  logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dvalid_q, dvalid_d;
  logic                    upd_q, upd_d;
  logic [c_idx_w-1:0]      upd_idx_q, upd_idx_d;
  logic                    code_err_q, code_err_d;
  logic                    sel_err_q, sel_err_d;

  // Combinational helpers
  int                      n_low;
  logic [c_idx_w-1:0]      sel_idx;
  logic                    sel_one, sel_multi, same, commit;
  logic [4:0]              dec;

`ifdef SEG7_DP_CAPTURE_EN
  logic                    dp_s_q, dp_s_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
`else
  logic                    unused_dp_bit;
  assign unused_dp_bit = seg_code[7];
`endif

  // Returns {valid, nibble} for a 7-bit segment pattern
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    case (code)
      7'h3F: seg_decode = 5'h10;
      7'h06: seg_decode = 5'h11;
      7'h5B: seg_decode = 5'h12;
      7'h4F: seg_decode = 5'h13;
      7'h66: seg_decode = 5'h14;
      7'h6D: seg_decode = 5'h15;
      7'h7D: seg_decode = 5'h16;
      7'h07: seg_decode = 5'h17;
      7'h7F: seg_decode = 5'h18;
      7'h6F: seg_decode = 5'h19;
      7'h77: seg_decode = 5'h1A;
      7'h7C: seg_decode = 5'h1B;
      7'h39: seg_decode = 5'h1C;
      7'h5E: seg_decode = 5'h1D;
      7'h79: seg_decode = 5'h1E;
      7'h71: seg_decode = 5'h1F;
      default: seg_decode = 5'h00;
    endcase
  endfunction

  // Next-state logic: sampling, run counter, commit and error pulses
  always_comb begin
    an_s_d  = an_n;
    seg_s_d = seg_code[6:0];
    an_p_d  = an_s_q;
    seg_p_d = seg_s_q;

    n_low   = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s_q[i]) begin
        n_low   = n_low + 1;
        sel_idx = c_idx_w'(i);
      end
    end
    sel_one   = (n_low == 1);
    sel_multi = (n_low > 1);
    same      = (an_s_q == an_p_q) && (seg_s_q == seg_p_q);

    // Blank or multi-select samples break the run
    if (sel_one) begin
      if (same) cnt_d = (cnt_q == c_stable) ? cnt_q : cnt_q + c_cnt_w'(1);
      else      cnt_d = c_cnt_w'(1);
    end else begin
      cnt_d = '0;
    end

    // Commit only on the sample where the count first reaches the threshold
    commit = sel_one && (cnt_d == c_stable) && !(same && (cnt_q == c_stable));
    dec    = seg_decode(seg_s_q);

    digits_d   = digits_q;
    dvalid_d   = dvalid_q;
    upd_d      = 1'b0;
    upd_idx_d  = upd_idx_q;
    code_err_d = 1'b0;
    sel_err_d  = sel_multi;
`ifdef SEG7_DP_CAPTURE_EN
    dp_s_d = seg_code[7];
    dp_d   = dp_q;
`endif

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit && !an_s_q[i]) begin
        if (dec[4]) begin
          digits_d[4*i +: 4] = dec[3:0];
          dvalid_d[i]        = 1'b1;
        end else begin
          dvalid_d[i]        = 1'b0;
        end
`ifdef SEG7_DP_CAPTURE_EN
        dp_d[i] = dp_s_q;
`endif
      end
    end

    if (commit) begin
      if (dec[4]) begin
        upd_d     = 1'b1;
        upd_idx_d = sel_idx;
      end else begin
        code_err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s_q     <= '0;
      seg_s_q    <= '0;
      an_p_q     <= '0;
      seg_p_q    <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      dvalid_q   <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
      code_err_q <= 1'b0;
      sel_err_q  <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      dp_s_q     <= 1'b0;
      dp_q       <= '0;
`endif
    end else begin
      an_s_q     <= an_s_d;
      seg_s_q    <= seg_s_d;
      an_p_q     <= an_p_d;
      seg_p_q    <= seg_p_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      dvalid_q   <= dvalid_d;
      upd_q      <= upd_d;
      upd_idx_q  <= upd_idx_d;
      code_err_q <= code_err_d;
      sel_err_q  <= sel_err_d;
`ifdef SEG7_DP_CAPTURE_EN
      dp_s_q     <= dp_s_d;
      dp_q       <= dp_d;
`endif
    end
  end

  assign digits   = digits_q;
  assign dvalid   = dvalid_q;
  assign upd      = upd_q;
  assign upd_idx  = upd_idx_q;
  assign code_err = code_err_q;
  assign sel_err  = sel_err_q;
`ifdef SEG7_DP_CAPTURE_EN
  assign dp       = dp_q;
`else
  assign dp       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_decode
// Description : Scoreboard bench for seg7_scan_decode. Each driven run that
//               should commit pushes its expected result and commit cycle;
//               the monitor pops on every upd/code_err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decode;

  localparam int ND = 8;
  localparam int SC = 4;
`ifdef SEG7_DP_CAPTURE_EN
  localparam bit DPE = 1'b1;
`else
  localparam bit DPE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      seg_code;
  logic [ND-1:0]   an_n;
  logic [ND*4-1:0] digits;
  logic [ND-1:0]   dvalid;
  logic            upd;
  logic [2:0]      upd_idx;
  logic            code_err;
  logic            sel_err;
  logic [ND-1:0]   dp;

  seg7_scan_decode #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_code(seg_code), .an_n(an_n),
    .digits(digits), .dvalid(dvalid), .upd(upd), .upd_idx(upd_idx),
    .code_err(code_err), .sel_err(sel_err), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_sel   = 0;
  int n_upd   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       idx;
    bit       ok;
    logic [3:0] nib;
    bit       dpb;
    int       when;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] m_dig [ND];
  bit         m_val [ND];
  bit         m_dp  [ND];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_lut(input logic [6:0] c, output logic [3:0] nib);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    nib = 4'h0;
    for (int j = 0; j < 16; j++)
      if (tbl[j] == c) begin
        nib = 4'(j);
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ND; i++) begin
      m_dig[i] = 4'h0;
      m_val[i] = 1'b0;
      m_dp[i]  = 1'b0;
    end
  endtask

  // Drive a pattern for n sampling edges; previous pattern must differ.
  task automatic drive(input logic [ND-1:0] an, input logic [7:0] seg, input int n);
    exp_t e;
    int   nl;
    @(negedge clk);
    an_n     = an;
    seg_code = seg;
    nl = 0;
    for (int i = 0; i < ND; i++) if (!an[i]) begin nl++; e.idx = i; end
    if (nl == 1 && n >= SC) begin
      e.ok   = tb_lut(seg[6:0], e.nib);
      e.dpb  = DPE & seg[7];
      e.when = cyc + 1 + SC;
      sb.push_back(e);
      if (e.ok) begin
        m_dig[e.idx] = e.nib;
        m_val[e.idx] = 1'b1;
      end else begin
        m_val[e.idx] = 1'b0;
      end
      m_dp[e.idx] = e.dpb;
    end
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic blank();
    drive('1, 8'h00, 3);
  endtask

  task automatic check_state(input string tag);
    logic [ND*4-1:0] vd;
    logic [ND-1:0]   vv, vp;
    for (int i = 0; i < ND; i++) begin
      vd[4*i +: 4] = m_dig[i];
      vv[i]        = m_val[i];
      vp[i]        = m_dp[i];
    end
    check_val({tag, "_digits"}, 64'(digits), 64'(vd));
    check_val({tag, "_dvalid"}, 64'(dvalid), 64'(vv));
    check_val({tag, "_dp"},     64'(dp),     64'(vp));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_digits"},   64'(digits),   64'd0);
    check_val({tag, "_dvalid"},   64'(dvalid),   64'd0);
    check_val({tag, "_upd"},      64'(upd),      64'd0);
    check_val({tag, "_upd_idx"},  64'(upd_idx),  64'd0);
    check_val({tag, "_code_err"}, 64'(code_err), 64'd0);
    check_val({tag, "_sel_err"},  64'(sel_err),  64'd0);
    check_val({tag, "_dp"},       64'(dp),       64'd0);
  endtask

  // Monitor: pop the scoreboard on each commit pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (sel_err) n_sel++;
      if (upd) n_upd++;
      if (upd && code_err) check_val("upd_with_code_err", 64'd1, 64'd0);
      if (upd || code_err) begin
        if (sb.size() == 0) begin
          check_val("unexpected_commit", 64'({upd, code_err}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_val("commit_kind",  64'(upd), 64'(mon_e.ok));
          check_val("commit_cycle", 64'(cyc), 64'(mon_e.when));
          check_val("commit_dvalid", 64'(dvalid[mon_e.idx]), 64'(mon_e.ok));
          check_val("commit_dp",    64'(dp[mon_e.idx]), 64'(mon_e.dpb));
          if (mon_e.ok) begin
            check_val("upd_idx", 64'(upd_idx), 64'(mon_e.idx));
            check_val("nibble",  64'(digits[4*mon_e.idx +: 4]), 64'(mon_e.nib));
          end
        end
      end
    end
  end

  logic [7:0] codes [8];
  int         s0;

  initial begin
    codes = '{8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'h87, 8'hFF};
    rst      = 1'b1;
    an_n     = '1;
    seg_code = 8'h00;
    model_clear();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // 1: single digit '0' on digit 0
    drive(8'hFE, 8'hBF, SC + 2);
    blank();
    check_state("t1");
    check_val("t1_digit0", 64'(digits[3:0]), 64'h0);

    // 2: scan all digits with 1..8
    s0 = n_upd;
    for (int i = 0; i < ND; i++) drive(~(8'(1) << i), codes[i], 6);
    blank();
    check_val("t2_upd_count", 64'(n_upd - s0), 64'd8);
    check_val("t2_digits", 64'(digits), 64'h87654321);
    check_val("t2_dvalid", 64'(dvalid), 64'hFF);
    check_state("t2");

    // 3: invalid code on digit 2
    s0 = n_upd;
    drive(8'hFB, 8'h80, 5);
    blank();
    check_val("t3_no_upd", 64'(n_upd - s0), 64'd0);
    check_val("t3_digit2", 64'(digits[11:8]), 64'h3);
    check_val("t3_dvalid2", 64'(dvalid[2]), 64'd0);
    check_state("t3");

    // 4: multi-select, then a run that is too short
    s0 = n_sel;
    drive(8'hFC, 8'h3F, 3);
    blank();
    check_val("t4_sel_err_count", 64'(n_sel - s0), 64'd3);
    drive(8'hFD, 8'hF7, SC - 1);
    blank();
    check_state("t4");

    // 5: reset in the middle of a run
    @(negedge clk);
    an_n     = 8'hFE;
    seg_code = 8'h06;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("t5_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t e;
      e.idx = 0; e.ok = 1'b1; e.nib = 4'h1; e.dpb = 1'b0; e.when = cyc + 1 + SC;
      sb.push_back(e);
      m_dig[0] = 4'h1;
      m_val[0] = 1'b1;
    end
    repeat (SC + 1) @(negedge clk);
    blank();
    check_state("t5");

    // 6: decimal-point capture on digit 3
    drive(8'hF7, 8'h6F, 5);
    blank();
    check_val("t6_digit3", 64'(digits[15:12]), 64'h9);
    check_val("t6_dp3_off", 64'(dp[3]), 64'd0);
    drive(8'hF7, 8'hEF, 5);
    blank();
    check_val("t6_dp3_on", 64'(dp[3]), 64'(DPE));
    check_state("t6");

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
